// File: rtl/pll_reconfig_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer: register map,
// sequencer states and error codes.
package pll_reconfig_pkg;

  localparam logic [5:0] REG_MODE   = 6'h00;
  localparam logic [5:0] REG_STATUS = 6'h01;
  localparam logic [5:0] REG_START  = 6'h02;
  localparam logic [5:0] REG_N      = 6'h03;
  localparam logic [5:0] REG_M      = 6'h04;
  localparam logic [5:0] REG_C      = 6'h05;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_POLL = 2'd1;
  localparam logic [1:0] ERR_LOCK = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_MODE,
    S_WR_N,
    S_WR_M,
    S_WR_C,
    S_WR_START,
    S_GAP,
    S_POLL,
    S_WAIT_LOCK,
    S_FIN,
    S_FAIL
  } state_t;

  // States that own an Avalon transfer.
  function automatic logic is_bus_state(state_t s);
    return s inside {S_WR_MODE, S_WR_N, S_WR_M, S_WR_C, S_WR_START, S_POLL};
  endfunction

endpackage

// File: rtl/avm_single_xfer.sv
// One Avalon-MM read or write per start pulse; strobe is high from the cycle after
// start until the cycle waitrequest is low, then drops. Address/data held through stalls.
module avm_single_xfer (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        start,
  input  logic        rd,
  input  logic [5:0]  addr,
  input  logic [31:0] wdata,
  output logic        active,
  output logic        complete,
  output logic [31:0] rdata,
  output logic [5:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  assign active   = avm_read | avm_write;
  assign complete = active & ~avm_waitrequest;
  assign rdata    = avm_readdata;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      avm_address   <= '0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
    end else if (start && !active) begin
      avm_address   <= addr;
      avm_read      <= rd;
      avm_write     <= ~rd;
      avm_writedata <= rd ? 32'd0 : wdata;
    end else if (complete) begin
      avm_read  <= 1'b0;
      avm_write <= 1'b0;
    end
  end

endmodule

// File: rtl/pll_reconfig_seq.sv
// Writes mode/N/M/C/start to the PLL reconfig slave, polls status, waits for lock.
// Min latency accept->done = 14 + POLL_GAP cycles; stalls extend it, requests while busy are dropped.
module pll_reconfig_seq
  import pll_reconfig_pkg::*;
#(
  parameter int POLL_GAP   = 16,
  parameter int POLL_LIMIT = 4096,
  parameter int LOCK_LIMIT = 65536,
  parameter int CNT_W      = 18
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_n,
  input  logic [CNT_W-1:0] cfg_m,
  input  logic [CNT_W-1:0] cfg_c,
  input  logic [4:0]       cfg_c_sel,
  input  logic             pll_locked,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [5:0]       avm_address,
  output logic             avm_read,
  output logic             avm_write,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  input  logic             avm_waitrequest
);

  localparam int GAP_W  = $clog2(POLL_GAP + 1);
  localparam int POLL_W = $clog2(POLL_LIMIT + 1);
  localparam int LOCK_W = $clog2(LOCK_LIMIT + 1);

  state_t state, state_next;

  logic [CNT_W-1:0]  n_q, m_q, c_q;
  logic [4:0]        csel_q;
  logic [GAP_W-1:0]  gap_cnt;
  logic [POLL_W-1:0] poll_cnt;
  logic [LOCK_W-1:0] lock_cnt;

  logic        xfer_start, xfer_rd, xfer_active, xfer_done;
  logic [5:0]  xfer_addr;
  logic [31:0] xfer_wdata, xfer_rdata;
  logic [1:0]  fail_code;
  logic        accept;
  logic        unused_rdata;

  assign accept       = (state == S_IDLE) && cfg_valid;
  assign cfg_ready    = (state == S_IDLE);
  assign busy         = !(state inside {S_IDLE, S_FIN, S_FAIL});
  assign done         = (state == S_FIN);
  assign err          = (state == S_FAIL);
  assign unused_rdata = ^xfer_rdata[31:1];

  avm_single_xfer u_xfer (
    .clk_clk         (clk_clk),
    .reset_reset_n   (reset_reset_n),
    .start           (xfer_start),
    .rd              (xfer_rd),
    .addr            (xfer_addr),
    .wdata           (xfer_wdata),
    .active          (xfer_active),
    .complete        (xfer_done),
    .rdata           (xfer_rdata),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest)
  );

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) state <= S_IDLE;
    else                state <= state_next;
  end

  always_comb begin
    state_next = state;
    xfer_rd    = 1'b0;
    xfer_addr  = '0;
    xfer_wdata = '0;
    fail_code  = ERR_NONE;
    case (state)
      S_IDLE: if (cfg_valid) state_next = S_WR_MODE;
      S_WR_MODE: begin
        xfer_addr  = REG_MODE;
        xfer_wdata = 32'd1;
        if (xfer_done) state_next = S_WR_N;
      end
      S_WR_N: begin
        xfer_addr  = REG_N;
        xfer_wdata = 32'(n_q);
        if (xfer_done) state_next = S_WR_M;
      end
      S_WR_M: begin
        xfer_addr  = REG_M;
        xfer_wdata = 32'(m_q);
        if (xfer_done) state_next = S_WR_C;
      end
      S_WR_C: begin
        xfer_addr  = REG_C;
        xfer_wdata = 32'({csel_q, c_q});
        if (xfer_done) state_next = S_WR_START;
      end
      S_WR_START: begin
        xfer_addr  = REG_START;
        xfer_wdata = 32'd1;
        if (xfer_done) state_next = S_GAP;
      end
      S_GAP: if (gap_cnt >= GAP_W'(POLL_GAP - 1)) state_next = S_POLL;
      S_POLL: begin
        xfer_rd   = 1'b1;
        xfer_addr = REG_STATUS;
        if (xfer_done) begin
          if (xfer_rdata[0]) begin
            state_next = S_WAIT_LOCK;
          end else if (poll_cnt >= POLL_W'(POLL_LIMIT - 1)) begin
            state_next = S_FAIL;
            fail_code  = ERR_POLL;
          end else begin
            state_next = S_GAP;
          end
        end
      end
      S_WAIT_LOCK: begin
        if (pll_locked) begin
          state_next = S_FIN;
        end else if (lock_cnt >= LOCK_W'(LOCK_LIMIT - 1)) begin
          state_next = S_FAIL;
          fail_code  = ERR_LOCK;
        end
      end
      S_FIN:   state_next = S_IDLE;
      S_FAIL:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // The strobe is always low on the first cycle of a bus state, so this fires once per state.
    xfer_start = is_bus_state(state) && !xfer_active;
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      n_q      <= '0;
      m_q      <= '0;
      c_q      <= '0;
      csel_q   <= '0;
      gap_cnt  <= '0;
      poll_cnt <= '0;
      lock_cnt <= '0;
      err_code <= ERR_NONE;
    end else begin
      if (accept) begin
        n_q      <= cfg_n;
        m_q      <= cfg_m;
        c_q      <= cfg_c;
        csel_q   <= cfg_c_sel;
        poll_cnt <= '0;
        lock_cnt <= '0;
        err_code <= ERR_NONE;
      end

      if (state != S_GAP)                      gap_cnt <= '0;
      else if (gap_cnt < GAP_W'(POLL_GAP))     gap_cnt <= gap_cnt + 1'b1;

      if (state == S_POLL && xfer_done && !xfer_rdata[0] && poll_cnt < POLL_W'(POLL_LIMIT))
        poll_cnt <= poll_cnt + 1'b1;

      if (state == S_POLL && xfer_done && xfer_rdata[0])
        lock_cnt <= '0;
      else if (state == S_WAIT_LOCK && lock_cnt < LOCK_W'(LOCK_LIMIT))
        lock_cnt <= lock_cnt + 1'b1;

      if (fail_code != ERR_NONE) err_code <= fail_code;
    end
  end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed scenarios against a stalling Avalon slave model; a scoreboard of expected
// transfers and outcomes is checked by an independent monitor.
module tb_pll_reconfig_seq;

  localparam int G  = 4;
  localparam int PL = 4;
  localparam int LL = 100;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [17:0] cfg_n = '0, cfg_m = '0, cfg_c = '0;
  logic [4:0]  cfg_c_sel = '0;
  logic        pll_locked = 1'b1;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [5:0]  avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = '0;
  logic        avm_waitrequest = 1'b0;

  pll_reconfig_seq #(.POLL_GAP(G), .POLL_LIMIT(PL), .LOCK_LIMIT(LL), .CNT_W(18)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_c(cfg_c), .cfg_c_sel(cfg_c_sel),
    .pll_locked(pll_locked), .busy(busy), .done(done), .err(err), .err_code(err_code),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk_clk = ~clk_clk;

  int cyc = 0;
  always @(posedge clk_clk) cyc <= cyc + 1;

  typedef struct { logic rd; logic [5:0] addr; logic [31:0] data; } xfer_t;
  typedef struct { logic is_err; logic [1:0] code; int at; } outc_t;

  xfer_t exp_x[$];
  outc_t exp_o[$];
  int    read_cyc[$];
  int    total = 0, bad = 0, outcomes = 0;
  int    stall_cfg = 0, done_after = 0, reads_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic exp_xfer(input logic rd, input logic [5:0] addr, input logic [31:0] data);
    xfer_t x;
    x.rd = rd; x.addr = addr; x.data = data;
    exp_x.push_back(x);
  endtask

  // Slave: stalls each transfer stall_cfg cycles; status reports done from read #done_after on.
  initial begin : slave
    int stall_left;
    stall_left = 0;
    forever begin
      @(posedge clk_clk); #1;
      if (avm_read || avm_write) begin
        if (stall_left > 0) begin
          avm_waitrequest = 1'b1;
          stall_left--;
        end else begin
          avm_waitrequest = 1'b0;
          stall_left = stall_cfg;
          if (avm_read) begin
            avm_readdata = {16'hA5A5, 15'd0, (reads_seen >= done_after)};
            reads_seen++;
          end
        end
      end else begin
        avm_waitrequest = 1'b0;
        stall_left = stall_cfg;
      end
    end
  end

  initial begin : monitor
    logic        prev_stall, h_rd;
    logic [5:0]  h_addr;
    logic [31:0] h_data;
    xfer_t x;
    outc_t o;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk_clk);
      if (prev_stall && reset_reset_n) begin
        check("stall_hold_addr", 32'(avm_address), 32'(h_addr));
        check("stall_hold_data", avm_writedata, h_data);
        check("stall_hold_rd", 32'(avm_read), 32'(h_rd));
        check("stall_hold_wr", 32'(avm_write), 32'(!h_rd));
      end
      if (avm_read || avm_write) begin
        check("rd_wr_exclusive", 32'(avm_read & avm_write), 32'd0);
        h_addr = avm_address; h_data = avm_writedata; h_rd = avm_read;
        prev_stall = avm_waitrequest;
        if (!avm_waitrequest) begin
          if (exp_x.size() == 0) begin
            check("unexpected_xfer_addr", 32'(avm_address), 32'hFFFF_FFFF);
          end else begin
            x = exp_x.pop_front();
            check("xfer_kind_rd", 32'(avm_read), 32'(x.rd));
            check("xfer_addr", 32'(avm_address), 32'(x.addr));
            if (!x.rd) check("xfer_data", avm_writedata, x.data);
          end
          if (avm_read) read_cyc.push_back(cyc);
        end
      end else begin
        prev_stall = 1'b0;
      end
      if (done || err) begin
        if (exp_o.size() == 0) begin
          check("unexpected_outcome_done_err", 32'({done, err}), 32'd0);
        end else begin
          o = exp_o.pop_front();
          check("outcome_err", 32'(err), 32'(o.is_err));
          check("outcome_done", 32'(done), 32'(!o.is_err));
          check("outcome_err_code", 32'(err_code), 32'(o.code));
          check("outcome_cycle", 32'(cyc), 32'(o.at));
        end
        outcomes++;
      end
    end
  end

  task automatic run_req(input logic [17:0] n, m, c, input logic [4:0] csel,
                         input logic [31:0] wn, wm, wc, input int nreads,
                         input logic is_err, input logic [1:0] code, input int lat);
    outc_t o;
    exp_xfer(1'b0, 6'h00, 32'd1);
    exp_xfer(1'b0, 6'h03, wn);
    exp_xfer(1'b0, 6'h04, wm);
    exp_xfer(1'b0, 6'h05, wc);
    exp_xfer(1'b0, 6'h02, 32'd1);
    for (int i = 0; i < nreads; i++) exp_xfer(1'b1, 6'h01, 32'd0);
    @(negedge clk_clk);
    reads_seen = 0;
    check("cfg_ready_idle", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1; cfg_n = n; cfg_m = m; cfg_c = c; cfg_c_sel = csel;
    o.is_err = is_err; o.code = code; o.at = cyc + lat;
    exp_o.push_back(o);
    @(posedge clk_clk); #1;
    cfg_valid = 1'b0; cfg_n = 18'h2AAAA; cfg_m = 18'h15555; cfg_c = 18'h3C3C3; cfg_c_sel = 5'h0A;
    @(negedge clk_clk);
    check("busy_after_accept", 32'(busy), 32'd1);
    check("err_code_cleared", 32'(err_code), 32'd0);
  endtask

  task automatic wait_outcome(input int target, input int budget);
    for (int i = 0; i < budget && outcomes < target; i++) @(posedge clk_clk);
    check("outcome_arrived", 32'(outcomes), 32'(target));
  endtask

  task automatic after_outcome(input logic [1:0] code);
    @(negedge clk_clk);
    check("pulse_done_low", 32'(done), 32'd0);
    check("pulse_err_low", 32'(err), 32'd0);
    check("busy_low", 32'(busy), 32'd0);
    check("cfg_ready_back", 32'(cfg_ready), 32'd1);
    check("err_code_held", 32'(err_code), 32'(code));
    check("xfer_queue_empty", 32'(exp_x.size()), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk_clk);
    check("rst_read", 32'(avm_read), 32'd0);
    check("rst_write", 32'(avm_write), 32'd0);
    check("rst_addr", 32'(avm_address), 32'd0);
    check("rst_wdata", avm_writedata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_err", 32'({done, err}), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);

    // 1: no stalls, status done at once, lock already high: minimum latency 14+G.
    stall_cfg = 0; done_after = 0;
    run_req(18'h00101, 18'h00808, 18'h00404, 5'd0, 32'h101, 32'h808, 32'h404,
            1, 1'b0, 2'd0, 18);
    wait_outcome(1, 200);
    after_outcome(2'd0);

    // 2: three stall cycles on every transfer add 3 cycles to each of 6 transfers.
    stall_cfg = 3;
    run_req(18'h3FFFF, 18'h00001, 18'h3FFFF, 5'd5, 32'h3FFFF, 32'h1, 32'h17FFFF,
            1, 1'b0, 2'd0, 36);
    wait_outcome(2, 200);
    after_outcome(2'd0);

    // 3: status done on the fourth read; reads G+2 cycles apart.
    stall_cfg = 0; done_after = 3;
    read_cyc.delete();
    run_req(18'h12345, 18'h2ABCD, 18'h00001, 5'd31, 32'h12345, 32'h2ABCD, 32'h7C0001,
            4, 1'b0, 2'd0, 36);
    wait_outcome(3, 200);
    after_outcome(2'd0);
    check("poll_read_count", 32'(read_cyc.size()), 32'd4);
    for (int i = 1; i < read_cyc.size(); i++)
      check("poll_spacing", 32'(read_cyc[i] - read_cyc[i-1]), 32'(G + 2));

    // 4: status never done -> poll timeout after PL reads.
    done_after = 1000;
    run_req(18'h00010, 18'h00020, 18'h00030, 5'd2, 32'h10, 32'h20, 32'h80030,
            4, 1'b1, 2'd1, 35);
    wait_outcome(4, 200);
    after_outcome(2'd1);

    // 5: lock never arrives -> lock timeout after LL cycles in WAIT_LOCK.
    done_after = 0; pll_locked = 1'b0;
    run_req(18'h00007, 18'h00009, 18'h0000B, 5'd16, 32'h7, 32'h9, 32'h40000B,
            1, 1'b1, 2'd2, 13 + G + LL);
    wait_outcome(5, 300);
    after_outcome(2'd2);
    repeat (3) @(negedge clk_clk);
    check("err_code_sticky", 32'(err_code), 32'd2);
    pll_locked = 1'b1;
    run_req(18'h00101, 18'h00808, 18'h00404, 5'd0, 32'h101, 32'h808, 32'h404,
            1, 1'b0, 2'd0, 18);
    wait_outcome(6, 200);
    after_outcome(2'd0);

    // 6: reset during the WR_M stall; a request pulsed while busy must be dropped.
    stall_cfg = 3;
    exp_xfer(1'b0, 6'h00, 32'd1);
    exp_xfer(1'b0, 6'h03, 32'h00055);
    @(negedge clk_clk);
    cfg_valid = 1'b1; cfg_n = 18'h00055; cfg_m = 18'h00066; cfg_c = 18'h00077; cfg_c_sel = 5'd1;
    @(posedge clk_clk); #1;
    cfg_valid = 1'b0;
    @(negedge clk_clk);
    check("cfg_ready_busy", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b1; cfg_n = 18'h11111; cfg_m = 18'h22222;
    @(posedge clk_clk); #1;
    cfg_valid = 1'b0;
    @(negedge clk_clk);
    for (int i = 0; i < 100 && !(avm_write && avm_address == 6'h04); i++) @(negedge clk_clk);
    check("reached_wr_m_stall", 32'({avm_write, avm_waitrequest, avm_address}), 32'h0C4);
    reset_reset_n = 1'b0;
    @(negedge clk_clk);
    check("mid_rst_strobes", 32'({avm_read, avm_write}), 32'd0);
    check("mid_rst_addr", 32'(avm_address), 32'd0);
    check("mid_rst_wdata", avm_writedata, 32'd0);
    check("mid_rst_status", 32'({busy, done, err, err_code}), 32'd0);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    check("post_rst_cfg_ready", 32'(cfg_ready), 32'd1);
    repeat (40) @(negedge clk_clk);
    check("post_rst_no_xfers", 32'(exp_x.size()), 32'd0);
    check("post_rst_no_outcome", 32'(outcomes), 32'd6);
    check("outcome_queue_empty", 32'(exp_o.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
